// File: rtl/divmod_arbiter_if.sv
// Request/response bundle between the requesters and the shared divide/modulo unit.
// Requester i owns slice [i*DATAWIDTH +: DATAWIDTH] of req_a / req_b.
interface divmod_arbiter_if #(
  parameter int DATAWIDTH = 32,
  parameter int NREQ      = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]                  req_valid;
  logic [NREQ-1:0]                  req_ready;
  logic signed [NREQ*DATAWIDTH-1:0] req_a;
  logic signed [NREQ*DATAWIDTH-1:0] req_b;
  logic [NREQ-1:0]                  rsp_valid;
  logic [IDW-1:0]                   rsp_id;
  logic signed [DATAWIDTH-1:0]      rsp_quot;
  logic signed [DATAWIDTH-1:0]      rsp_rem;
  logic                             rsp_dz;
  logic                             busy;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dz, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_dz, busy
  );
endinterface

// File: rtl/divmod_arbiter.sv
// Round-robin arbiter in front of one shared signed divide/modulo datapath.
// Each accepted operation holds the unit LATENCY cycles, then pulses rsp_valid once.
module divmod_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int NREQ      = 4,
  parameter int LATENCY   = 2
) (
  input logic             clk,
  input logic             rst,
  divmod_arbiter_if.slave bus
);
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW   = IDW + 1;
  localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                        dz;
    logic signed [DATAWIDTH-1:0] quot;
    logic signed [DATAWIDTH-1:0] rem;
  } result_t;

  state_t                      state_q;
  logic [IDW-1:0]              ptr_q;
  logic [IDW-1:0]              id_q;
  logic [CNTW-1:0]             cnt_q;
  logic [NREQ-1:0]             rsp_valid_q;
  logic [IDW-1:0]              rsp_id_q;
  logic signed [DATAWIDTH-1:0] rsp_quot_q;
  logic signed [DATAWIDTH-1:0] rsp_rem_q;
  logic                        rsp_dz_q;
  logic signed [DATAWIDTH-1:0] a_q;
  logic signed [DATAWIDTH-1:0] b_q;

  logic signed [DATAWIDTH-1:0] a_arr [NREQ];
  logic signed [DATAWIDTH-1:0] b_arr [NREQ];
  logic [SW-1:0]               sum;
  logic [IDW-1:0]              cand;
  logic [IDW-1:0]              win;
  logic                        found;
  logic [NREQ-1:0]             grant;
  logic                        accept;
  result_t                     res;

  // Magnitude divide then re-sign: truncation toward zero, remainder follows the dividend.
  // MIN / -1 falls out naturally as |MIN| re-negated, which wraps back to MIN.
  function automatic result_t divmod(input logic signed [DATAWIDTH-1:0] a,
                                     input logic signed [DATAWIDTH-1:0] b);
    result_t              r;
    logic [DATAWIDTH-1:0] ua;
    logic [DATAWIDTH-1:0] ub;
    logic [DATAWIDTH-1:0] uq;
    logic [DATAWIDTH-1:0] ur;
    r.dz   = 1'b0;
    r.quot = '0;
    r.rem  = a;
    ua     = '0;
    ub     = '0;
    uq     = '0;
    ur     = '0;
    if (b == '0) begin
      r.dz = 1'b1;
    end else begin
      ua     = a[DATAWIDTH-1] ? -a : a;
      ub     = b[DATAWIDTH-1] ? -b : b;
      uq     = ua / ub;
      ur     = ua % ub;
      r.quot = (a[DATAWIDTH-1] ^ b[DATAWIDTH-1]) ? -uq : uq;
      r.rem  = a[DATAWIDTH-1] ? -ur : ur;
    end
    return r;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = bus.req_a[g*DATAWIDTH +: DATAWIDTH];
    assign b_arr[g] = bus.req_b[g*DATAWIDTH +: DATAWIDTH];
  end

  // Round-robin search starting at ptr_q, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_q} + SW'(i);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      cand = sum[IDW-1:0];
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    grant = '0;
    if ((state_q == IDLE) && !rst && found) grant[win] = 1'b1;
  end

  assign accept = |grant;
  assign res    = divmod(a_q, b_q);

  // Control and visible result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_quot_q  <= '0;
      rsp_rem_q   <= '0;
      rsp_dz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            id_q    <= win;
            cnt_q   <= CNTW'(LATENCY - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            rsp_quot_q  <= res.quot;
            rsp_rem_q   <= res.rem;
            rsp_dz_q    <= res.dz;
            rsp_id_q    <= id_q;
            rsp_valid_q <= {{(NREQ-1){1'b0}}, 1'b1} << id_q;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          rsp_valid_q <= '0;
          ptr_q       <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand capture at acceptance; later input changes cannot disturb the operation.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a_arr[win];
      b_q <= b_arr[win];
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_quot  = rsp_quot_q;
  assign bus.rsp_rem   = rsp_rem_q;
  assign bus.rsp_dz    = rsp_dz_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_divmod_arbiter.sv
// Bench for divmod_arbiter: directed corner cases, reset abort, fairness sweep and random traffic
// compared against a plain-arithmetic reference and a round-robin pointer model.
module tb_divmod_arbiter;
  localparam int DW  = 32;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  divmod_arbiter_if #(.DATAWIDTH(DW), .NREQ(N)) bus ();

  divmod_arbiter #(.DATAWIDTH(DW), .NREQ(N), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ptr_m = 0;
  int last_acc = 0;
  int ta [N];
  int tb [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*DW +: DW] = ta[i];
      bus.req_b[i*DW +: DW] = tb[i];
    end
  endtask

  task automatic ref_div(input int a, input int b, output int q, output int r, output bit dz);
    longint la, lb, lq;
    la = a;
    lb = b;
    if (b == 0) begin
      q = 0; r = a; dz = 1'b1;
    end else begin
      lq = la / lb;
      q  = int'(lq);
      r  = int'(la - lq * lb);
      dz = 1'b0;
    end
  endtask

  function automatic int model_winner(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[(ptr_m + i) % N]) return (ptr_m + i) % N;
    end
    return -1;
  endfunction

  function automatic int rnd_op();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return int'(32'h8000_0000);
      2: return -1;
      3: return int'($urandom_range(0, 40)) - 20;
      default: return int'($urandom);
    endcase
  endfunction

  task automatic accept(input logic [N-1:0] mask, input bit keep, input bit space,
                        output int g, output int a, output int b);
    int k = 0;
    pack();
    bus.req_valid = mask;
    #1;
    while (bus.req_ready == '0 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    g = model_winner(mask);
    if (g < 0) g = 0;
    chk("grant", 64'(bus.req_ready), 64'(1 << g));
    if (space) chk("spacing", 64'(cyc - last_acc), 64'(LAT + 2));
    last_acc = cyc;
    a = ta[g];
    b = tb[g];
    @(posedge clk); #1;
    if (!keep) bus.req_valid = '0;
    ta[g] = int'($urandom);
    tb[g] = int'($urandom);
    pack();
    chk("busy", 64'(bus.busy), 64'(1));
    chk("rdy_in_busy", 64'(bus.req_ready), 64'(0));
  endtask

  task automatic finish_rsp(input int g, input int a, input int b);
    int k = 0;
    int q, r;
    bit dz;
    ref_div(a, b, q, r, dz);
    while (bus.rsp_valid == '0 && k < 10) begin
      @(posedge clk); #1; k++;
    end
    chk("latency", 64'(k), 64'(LAT));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(1 << g));
    chk("rsp_id", 64'(bus.rsp_id), 64'(g));
    chk("quot", 64'(bus.rsp_quot), 64'(q));
    chk("rem", 64'(bus.rsp_rem), 64'(r));
    chk("dz", 64'(bus.rsp_dz), 64'(dz));
    ptr_m = (g + 1) % N;
    @(posedge clk); #1;
    chk("rsp_pulse", 64'(bus.rsp_valid), 64'(0));
    chk("busy_idle", 64'(bus.busy), 64'(0));
    chk("hold_quot", 64'(bus.rsp_quot), 64'(q));
    chk("hold_rem", 64'(bus.rsp_rem), 64'(r));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(0));
    chk({tag, "_quot"}, 64'(bus.rsp_quot), 64'(0));
    chk({tag, "_rem"}, 64'(bus.rsp_rem), 64'(0));
    chk({tag, "_dz"}, 64'(bus.rsp_dz), 64'(0));
    chk({tag, "_id"}, 64'(bus.rsp_id), 64'(0));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    @(posedge clk); #1;
    chk("rst_ready", 64'(bus.req_ready), 64'(0));
    @(posedge clk); #1;
    chk("rst_ready2", 64'(bus.req_ready), 64'(0));
    chk_zero_outputs("rst");
    ptr_m = 0;
  endtask

  int da [5];
  int db [5];
  int dq [5];
  int dr [5];
  int g, a, b;
  logic [N-1:0] mask;

  initial begin
    da = '{17, -17, 17, 42, int'(32'h8000_0000)};
    db = '{5, 5, -5, 0, -1};
    dq = '{3, -3, -3, 0, int'(32'h8000_0000)};
    dr = '{2, -2, 2, 42, 0};
    for (int i = 0; i < N; i++) begin
      ta[i] = 0;
      tb[i] = 1;
    end
    bus.req_valid = '0;
    pack();

    do_reset();
    bus.req_valid = '0;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      ta[0] = da[i];
      tb[0] = db[i];
      accept(4'b0001, 1'b0, 1'b0, g, a, b);
      finish_rsp(g, a, b);
      chk("dir_quot", 64'(bus.rsp_quot), 64'(dq[i]));
      chk("dir_rem", 64'(bus.rsp_rem), 64'(dr[i]));
      chk("dir_dz", 64'(bus.rsp_dz), 64'(db[i] == 0));
    end

    do_reset();
    for (int i = 0; i < N; i++) begin
      ta[i] = rnd_op();
      tb[i] = rnd_op();
    end
    bus.req_valid = '1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      accept('1, 1'b1, i > 0, g, a, b);
      chk("rr_order", 64'(g), 64'(i % N));
      finish_rsp(g, a, b);
    end
    bus.req_valid = '0;
    @(posedge clk); #1;

    ta[2] = 100;
    tb[2] = 7;
    accept(4'b0100, 1'b0, 1'b0, g, a, b);
    rst = 1'b1;
    bus.req_valid = 4'b1010;
    #1;
    chk("abort_ready", 64'(bus.req_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero_outputs("abort");
    bus.req_valid = '0;
    ptr_m = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", 64'(bus.rsp_valid), 64'(0));
    end
    accept(4'b1010, 1'b0, 1'b0, g, a, b);
    chk("abort_next", 64'(g), 64'(1));
    finish_rsp(g, a, b);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        ta[i] = rnd_op();
        tb[i] = rnd_op();
      end
      mask = 4'($urandom_range(1, 15));
      accept(mask, 1'b0, 1'b0, g, a, b);
      finish_rsp(g, a, b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/divmod_arbiter.md
DIVMOD_ARBITER -- requirements
Module: divmod_arbiter

Interface
REQ-001 Parameter DATAWIDTH, default 32: operand and result width in bits.
REQ-002 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-003 Parameter LATENCY, default 2: cycles the shared divide unit is held per operation; legal values >= 1.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  NREQ  bit i set means requester i has an operation pending.
REQ-007 req_ready  output  NREQ  one-hot grant; bit i set means requester i's operands are accepted this cycle.
REQ-008 req_a  input  NREQ*DATAWIDTH  signed dividends; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH].
REQ-009 req_b  input  NREQ*DATAWIDTH  signed divisors, packed the same way as req_a.
REQ-010 rsp_valid  output  NREQ  one-hot; bit i pulses for one cycle when requester i's result is ready.
REQ-011 rsp_id  output  clog2(NREQ)  index of the requester that owns the current or most recent result.
REQ-012 rsp_quot  output  DATAWIDTH  signed quotient.
REQ-013 rsp_rem  output  DATAWIDTH  signed remainder.
REQ-014 rsp_dz  output  1  divide-by-zero flag for the result.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 FSM states are IDLE, BUSY and RESP; the block holds exactly one shared signed divide/modulo datapath.
REQ-017 In IDLE, if any req_valid bit is set, the block SHALL combinationally raise the req_ready bit of the winner; no other req_ready bit is raised.
REQ-018 Winner selection is round-robin: search begins at pointer ptr and advances upward modulo NREQ; the first set req_valid bit wins.
REQ-019 Acceptance occurs at the rising edge where req_valid[g] and req_ready[g] are both high; at that edge the block captures req_a[g], req_b[g] and g, loads cnt = LATENCY-1 and moves to BUSY.
REQ-020 In BUSY, req_ready is all zeros; cnt decrements on each edge; at the edge where cnt==0 the block registers the results into rsp_quot, rsp_rem, rsp_dz and rsp_id and moves to RESP.
REQ-021 In RESP, rsp_valid[g] is high for exactly one cycle; on the next edge ptr = (g+1) mod NREQ and the FSM returns to IDLE.
REQ-022 Timing: rsp_valid rises LATENCY cycles after the acceptance edge; the minimum spacing between successive acceptances is LATENCY+2 cycles.
REQ-023 Arithmetic: quotient truncates toward zero; the remainder takes the sign of the dividend; a = quot*b + rem.
REQ-024 Divisor zero: rsp_quot = 0, rsp_rem = captured a, rsp_dz = 1.
REQ-025 Most-negative value divided by -1: rsp_quot = most-negative value (wraps), rsp_rem = 0, rsp_dz = 0.
REQ-026 rsp_quot, rsp_rem, rsp_dz and rsp_id hold their values after RESP until the next RESP load.
REQ-027 Changes to req_valid, req_a or req_b after acceptance do not affect the operation in flight.
REQ-028 A requester that deasserts req_valid while in IDLE and not yet accepted is not granted; arbitration re-evaluates every IDLE cycle.

Reset
REQ-029 While rst is high at a clock edge: FSM goes to IDLE, ptr = 0, cnt = 0, rsp_valid = 0, rsp_quot = 0, rsp_rem = 0, rsp_dz = 0, rsp_id = 0, busy = 0.
REQ-030 Reset asserted during BUSY or RESP aborts the operation and no rsp_valid pulse is produced for it.
REQ-031 req_ready is all zeros in any cycle where rst is high.

Verification (DATAWIDTH=32, NREQ=4, LATENCY=2)
REQ-032 Requester 0 only, a=17, b=5 -> req_ready[0] high at acceptance; rsp_valid[0] high 2 cycles later; quot=3, rem=2, dz=0, id=0.
REQ-033 a=-17, b=5 -> quot=-3, rem=-2; and a=17, b=-5 -> quot=-3, rem=2.
REQ-034 a=42, b=0 -> quot=0, rem=42, dz=1.
REQ-035 a=32'h80000000, b=-1 -> quot=32'h80000000, rem=0, dz=0.
REQ-036 All four req_valid held high from reset release -> grant order 0,1,2,3,0, acceptances exactly 4 cycles apart, each rsp_valid one-hot with matching rsp_id.
REQ-037 rst pulsed one cycle while BUSY with requester 2 active -> no rsp_valid pulse, all outputs 0; with requesters 1 and 3 then valid, the next grant goes to requester 1.
